// File: rtl/pipe_ctrl_n_pkg.sv
// Shared definitions for the pipeline controller.
//   - default geometry (stage count, EX stage index, address and counter widths)
//   - controller state encoding
//   - bit_range(): contiguous bit mask helper used to build the per-stage
//     hold/clear patterns
package pipe_ctrl_n_pkg;

   localparam int STAGES_DEF = 5;
   localparam int EX_IDX_DEF = 2;
   localparam int ADDR_W_DEF = 32;
   localparam int CNT_W_DEF  = 4;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_STALL = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   // Mask with bits lo..hi set (inclusive), hi < 31.
   function automatic logic [31:0] bit_range(input int lo, input int hi);
      logic [31:0] upper;
      logic [31:0] lower;
      upper = (32'd1 << (hi + 1)) - 32'd1;
      lower = (32'd1 << lo) - 32'd1;
      return upper & ~lower;
   endfunction

endpackage

// File: rtl/pipe_stall_cnt.sv
// Multi-cycle stall down-counter.
// Ports:
//   clk_100MHz  in   clock, rising edge
//   arst_n      in   asynchronous active-low reset, clears the count
//   load        in   load load_val (has priority over dec)
//   dec         in   decrement by one, saturating at zero
//   load_val    in   value to load
//   cnt         out  current count
// With neither load nor dec the count is frozen.
module pipe_stall_cnt
   import pipe_ctrl_n_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk_100MHz,
   input  logic             arst_n,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_ctrl_n.sv
// Pipeline hazard / stall / jump controller.
// Ports:
//   clk_100MHz      in   clock, rising edge
//   arst_n          in   asynchronous active-low reset
//   hold_i          in   external system hold (freezes every stage)
//   ex_hold_risk_i  in   single-cycle data hazard from EX
//   ex_stall_req_i  in   multi-cycle stall request from EX
//   ex_stall_cnt_i  in   stall length in cycles, sampled with ex_stall_req_i
//   ex_jump_i       in   branch/jump taken in EX
//   ex_jump_addr_i  in   jump target
//   hold_o          out  per-stage freeze (bit i keeps stage register i)
//   clr_o           out  per-stage flush (bit i loads a bubble into stage i)
//   jump_ena_o      out  redirect PC this cycle
//   jump_addr_o     out  redirect target
//   busy_o          out  STALL/HALT state or jump pending
//
// state | meaning
// RUN   | normal flow; accepts jump, stall and hazard requests from EX
// STALL | multi-cycle stall in progress; counter counts remaining cycles
// HALT  | external hold; remembers RUN/STALL, counter frozen, jumps captured
//
// The first cycle after a hold behaves like the remembered state. If a jump
// was captured during the hold, that cycle is spent on the redirect instead
// and the stall counter stays frozen, so the stall length is still exact.
module pipe_ctrl_n
   import pipe_ctrl_n_pkg::*;
#(
   parameter int STAGES = STAGES_DEF,
   parameter int EX_IDX = EX_IDX_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk_100MHz,
   input  logic              arst_n,
   input  logic              hold_i,
   input  logic              ex_hold_risk_i,
   input  logic              ex_stall_req_i,
   input  logic [CNT_W-1:0]  ex_stall_cnt_i,
   input  logic              ex_jump_i,
   input  logic [ADDR_W-1:0] ex_jump_addr_i,
   output logic [STAGES-1:0] hold_o,
   output logic [STAGES-1:0] clr_o,
   output logic              jump_ena_o,
   output logic [ADDR_W-1:0] jump_addr_o,
   output logic              busy_o
);

   // Jump flushes the stages behind EX (not the PC itself).
   localparam logic [STAGES-1:0] JMP_CLR    = STAGES'(bit_range(1, EX_IDX));
   // Stall freezes PC..EX and bubbles the stage after EX.
   localparam logic [STAGES-1:0] STALL_HOLD = STAGES'(bit_range(0, EX_IDX));
   localparam logic [STAGES-1:0] STALL_CLR  = STAGES'(bit_range(EX_IDX + 1, EX_IDX + 1));
   // Hazard freezes everything ahead of EX and bubbles EX.
   localparam logic [STAGES-1:0] RISK_HOLD  = STAGES'(bit_range(0, EX_IDX - 1));
   localparam logic [STAGES-1:0] RISK_CLR   = STAGES'(bit_range(EX_IDX, EX_IDX));

   logic [1:0]        state, state_nx;
   logic [1:0]        ret_state, ret_nx;
   logic [1:0]        eff_state;
   logic              pend_vld, pend_nx;
   logic [ADDR_W-1:0] pend_addr, pend_addr_nx;
   logic              cnt_load, cnt_dec;
   logic [CNT_W-1:0]  cnt_load_val, cnt;

   assign eff_state    = (state == ST_HALT) ? ret_state : state;
   assign cnt_load_val = ex_stall_cnt_i - CNT_W'(1);

   pipe_stall_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk_100MHz (clk_100MHz),
      .arst_n     (arst_n),
      .load       (cnt_load),
      .dec        (cnt_dec),
      .load_val   (cnt_load_val),
      .cnt        (cnt)
   );

   always_comb begin
      state_nx     = state;
      ret_nx       = ret_state;
      pend_nx      = pend_vld;
      pend_addr_nx = pend_addr;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      hold_o       = '0;
      clr_o        = '0;
      jump_ena_o   = 1'b0;
      jump_addr_o  = '0;
      busy_o       = (state != ST_RUN) || pend_vld;

      if (hold_i) begin
         hold_o   = '1;
         state_nx = ST_HALT;
         if (state != ST_HALT) begin
            ret_nx = state;
         end
         if (ex_jump_i) begin
            pend_nx      = 1'b1;
            pend_addr_nx = ex_jump_addr_i;
         end
      end else if ((state == ST_HALT) && pend_vld) begin
         jump_ena_o  = 1'b1;
         jump_addr_o = pend_addr;
         clr_o       = JMP_CLR;
         pend_nx     = 1'b0;
         state_nx    = ret_state;
      end else if (eff_state == ST_STALL) begin
         hold_o   = STALL_HOLD;
         clr_o    = STALL_CLR;
         cnt_dec  = 1'b1;
         state_nx = (cnt <= CNT_W'(1)) ? ST_RUN : ST_STALL;
      end else begin
         state_nx = ST_RUN;
         if (ex_jump_i) begin
            jump_ena_o  = 1'b1;
            jump_addr_o = ex_jump_addr_i;
            clr_o       = JMP_CLR;
         end else if (ex_stall_req_i && (ex_stall_cnt_i != '0)) begin
            hold_o   = STALL_HOLD;
            clr_o    = STALL_CLR;
            cnt_load = 1'b1;
            state_nx = (ex_stall_cnt_i == CNT_W'(1)) ? ST_RUN : ST_STALL;
         end else if (ex_hold_risk_i) begin
            hold_o = RISK_HOLD;
            clr_o  = RISK_CLR;
         end
      end

      // Reset acts on the outputs immediately, not at the next edge.
      if (!arst_n) begin
         hold_o      = '0;
         clr_o       = '1;
         jump_ena_o  = 1'b0;
         jump_addr_o = '0;
         busy_o      = 1'b0;
      end
   end

   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         state     <= ST_RUN;
         ret_state <= ST_RUN;
         pend_vld  <= 1'b0;
         pend_addr <= '0;
      end else begin
         state     <= state_nx;
         ret_state <= ret_nx;
         pend_vld  <= pend_nx;
         pend_addr <= pend_addr_nx;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
module tb_pipe_ctrl_n;

   logic        clk_100MHz = 1'b0;
   logic        arst_n;
   logic        hold_i, ex_hold_risk_i, ex_stall_req_i, ex_jump_i;
   logic [3:0]  ex_stall_cnt_i;
   logic [31:0] ex_jump_addr_i;
   logic [4:0]  hold_o, clr_o;
   logic        jump_ena_o;
   logic [31:0] jump_addr_o;
   logic        busy_o;

   localparam logic [4:0] Z5  = 5'b00000;
   localparam logic [4:0] ALL = 5'b11111;
   localparam logic [4:0] SPH = 5'b00111;
   localparam logic [4:0] SPC = 5'b01000;
   localparam logic [4:0] JC  = 5'b00110;
   localparam logic [4:0] RH  = 5'b00011;
   localparam logic [4:0] RC  = 5'b00100;

   typedef struct packed {
      logic [4:0]  hold;
      logic [4:0]  clr;
      logic        jmp;
      logic [31:0] addr;
      logic        busy;
   } exp_t;

   exp_t  sb[$];
   string nm_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   always #5 clk_100MHz = ~clk_100MHz;

   pipe_ctrl_n dut (
      .clk_100MHz     (clk_100MHz),
      .arst_n         (arst_n),
      .hold_i         (hold_i),
      .ex_hold_risk_i (ex_hold_risk_i),
      .ex_stall_req_i (ex_stall_req_i),
      .ex_stall_cnt_i (ex_stall_cnt_i),
      .ex_jump_i      (ex_jump_i),
      .ex_jump_addr_i (ex_jump_addr_i),
      .hold_o         (hold_o),
      .clr_o          (clr_o),
      .jump_ena_o     (jump_ena_o),
      .jump_addr_o    (jump_addr_o),
      .busy_o         (busy_o)
   );

   // Monitor: compares the DUT outputs with the oldest expectation.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge clk_100MHz);
         if (sb.size() > 0) begin
            e  = sb.pop_front();
            nm = nm_q.pop_front();
            n_cmp++;
            if (hold_o !== e.hold || clr_o !== e.clr || jump_ena_o !== e.jmp ||
                jump_addr_o !== e.addr || busy_o !== e.busy) begin
               n_err++;
               $display("FAIL %s: got hold=%b clr=%b jmp=%b addr=%h busy=%b, want hold=%b clr=%b jmp=%b addr=%h busy=%b",
                        nm, hold_o, clr_o, jump_ena_o, jump_addr_o, busy_o,
                        e.hold, e.clr, e.jmp, e.addr, e.busy);
            end
         end
      end
   end

   // Drive one cycle of inputs (just after a rising edge) and queue the
   // expected combinational response for that cycle.
   task automatic vec(input logic h, input logic j, input logic s, input logic r,
                      input logic [3:0] n, input logic [31:0] a,
                      input logic [4:0] eh, input logic [4:0] ec, input logic ej,
                      input logic [31:0] ea, input logic eb, input string nm);
      exp_t e;
      hold_i         = h;
      ex_jump_i      = j;
      ex_stall_req_i = s;
      ex_hold_risk_i = r;
      ex_stall_cnt_i = n;
      ex_jump_addr_i = a;
      e.hold = eh; e.clr = ec; e.jmp = ej; e.addr = ea; e.busy = eb;
      sb.push_back(e);
      nm_q.push_back(nm);
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic idle(input logic eb, input string nm);
      vec(0, 0, 0, 0, 4'd0, 32'h0, Z5, Z5, 0, 32'h0, eb, nm);
   endtask

   initial begin
      arst_n = 1'b0;
      hold_i = 0; ex_jump_i = 0; ex_stall_req_i = 0; ex_hold_risk_i = 0;
      ex_stall_cnt_i = '0; ex_jump_addr_i = '0;
      @(posedge clk_100MHz);
      #1;
      vec(0, 0, 0, 0, 4'd0, 32'h0, Z5, ALL, 0, 32'h0, 0, "reset_state");
      arst_n = 1'b1;
      idle(0, "idle_run");

      // same-cycle jump
      vec(0, 1, 0, 0, 4'd0, 32'h100, Z5, JC, 1, 32'h100, 0, "jump_run");
      idle(0, "after_jump");

      // stall 3; jump in last stall cycle is ignored
      vec(0, 0, 1, 0, 4'd3, 32'h0, SPH, SPC, 0, 32'h0, 0, "stall3_c1");
      vec(0, 0, 0, 0, 4'd0, 32'h0, SPH, SPC, 0, 32'h0, 1, "stall3_c2");
      vec(0, 1, 0, 0, 4'd0, 32'h55, SPH, SPC, 0, 32'h0, 1, "stall3_c3");
      idle(0, "stall3_done");

      // stall 1 stays in RUN; stall 0 ignored
      vec(0, 0, 1, 0, 4'd1, 32'h0, SPH, SPC, 0, 32'h0, 0, "stall1");
      idle(0, "stall1_done");
      vec(0, 0, 1, 0, 4'd0, 32'h0, Z5, Z5, 0, 32'h0, 0, "stall0_ignored");

      // hazard, and hazard + jump
      vec(0, 0, 0, 1, 4'd0, 32'h0, RH, RC, 0, 32'h0, 0, "hazard");
      idle(0, "hazard_done");
      vec(0, 1, 0, 1, 4'd0, 32'h300, Z5, JC, 1, 32'h300, 0, "hazard_jump");
      vec(0, 1, 1, 0, 4'd5, 32'h400, Z5, JC, 1, 32'h400, 0, "stall_jump");
      idle(0, "stall_discarded");

      // stall 4 interrupted by 2 hold cycles
      vec(0, 0, 1, 0, 4'd4, 32'h0, SPH, SPC, 0, 32'h0, 0, "s4_c1");
      vec(1, 0, 0, 0, 4'd0, 32'h0, ALL, Z5, 0, 32'h0, 1, "s4_hold1");
      vec(1, 0, 0, 0, 4'd0, 32'h0, ALL, Z5, 0, 32'h0, 1, "s4_hold2");
      vec(0, 0, 0, 0, 4'd0, 32'h0, SPH, SPC, 0, 32'h0, 1, "s4_c2");
      vec(0, 0, 0, 0, 4'd0, 32'h0, SPH, SPC, 0, 32'h0, 1, "s4_c3");
      vec(0, 0, 0, 0, 4'd0, 32'h0, SPH, SPC, 0, 32'h0, 1, "s4_c4");
      idle(0, "s4_done");

      // jumps during hold are deferred; the later one wins
      vec(1, 1, 0, 0, 4'd0, 32'h100, ALL, Z5, 0, 32'h0, 0, "hj_c1");
      vec(1, 1, 0, 0, 4'd0, 32'h200, ALL, Z5, 0, 32'h0, 1, "hj_c2");
      vec(0, 0, 0, 0, 4'd0, 32'h0, Z5, JC, 1, 32'h200, 1, "hj_release");
      idle(0, "hj_done");

      // release from hold without pending jump acts as RUN
      vec(1, 0, 0, 0, 4'd0, 32'h0, ALL, Z5, 0, 32'h0, 0, "hr_hold");
      vec(0, 0, 0, 1, 4'd0, 32'h0, RH, RC, 0, 32'h0, 1, "hr_release_hazard");
      idle(0, "hr_done");

      // longest stall
      vec(0, 0, 1, 0, 4'd15, 32'h0, SPH, SPC, 0, 32'h0, 0, "s15_c1");
      for (int i = 2; i <= 15; i++) begin
         vec(0, 0, 0, 0, 4'd0, 32'h0, SPH, SPC, 0, 32'h0, 1, $sformatf("s15_c%0d", i));
      end
      idle(0, "s15_done");

      // reset in the middle of a stall
      vec(0, 0, 1, 0, 4'd7, 32'h0, SPH, SPC, 0, 32'h0, 0, "s7_c1");
      vec(0, 0, 0, 0, 4'd0, 32'h0, SPH, SPC, 0, 32'h0, 1, "s7_c2");
      arst_n = 1'b0;
      vec(0, 0, 0, 0, 4'd0, 32'h0, Z5, ALL, 0, 32'h0, 0, "s7_reset");
      arst_n = 1'b1;
      idle(0, "s7_post1");
      idle(0, "s7_post2");

      // reset in HALT drops the pending jump
      vec(1, 1, 0, 0, 4'd0, 32'h700, ALL, Z5, 0, 32'h0, 0, "hp_c1");
      vec(1, 0, 0, 0, 4'd0, 32'h0, ALL, Z5, 0, 32'h0, 1, "hp_c2");
      arst_n = 1'b0;
      vec(1, 0, 0, 0, 4'd0, 32'h0, Z5, ALL, 0, 32'h0, 0, "hp_reset");
      arst_n = 1'b1;
      idle(0, "hp_dropped");

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk_100MHz);
      #1;
      if (sb.size() > 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
